osd_ctm_trace_decoder: RTL and testbench

//   Receiving end of the core trace module (CTM) event stream: accepts DII flits from the debug
//   NoC, reassembles CTM trace-event packets addressed to this node into trace records, buffers

---
 rtl/osd_ctm_trace_decoder_pkg.sv | 40 ++++
 rtl/osd_ctm_trace_decoder_if.sv | 26 ++
 rtl/osd_ctm_rec_fifo.sv | 51 +++++
 rtl/osd_ctm_trace_decoder.sv | 147 ++++++++++++++
 tb/tb_osd_ctm_trace_decoder.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/osd_ctm_trace_decoder_pkg.sv
// Shared types and constants for the CTM trace-event decoder: DII flit, trace record,
// header codes and flag bit positions.
package ctm_dec_package;

    typedef struct packed {
        logic [15:0] data;
        logic        valid;
        logic        last;
    } dii_flit;

    // 'time' is a reserved word, so the timestamp field is time_stamp.
    typedef struct packed {
        logic [31:0] time_stamp;
        logic [31:0] npc;
        logic [31:0] pc;
        logic [7:0]  flags;
    } ctm_trace_rec_t;

    localparam logic [1:0]  TYPE_EVENT          = 2'b10;
    localparam logic [3:0]  SUB_TRACE           = 4'h0;
    localparam logic [3:0]  SUB_OVF             = 4'h5;
    localparam int unsigned TRACE_PAYLOAD_FLITS = 7;

    localparam int unsigned FLAG_JAL      = 0;
    localparam int unsigned FLAG_JALR     = 1;
    localparam int unsigned FLAG_BRANCH   = 2;
    localparam int unsigned FLAG_BR_TAKEN = 3;
    localparam int unsigned FLAG_XCPT     = 4;
    localparam int unsigned FLAG_TRAP     = 5;
    localparam int unsigned FLAG_PRV_LO   = 6;

    typedef enum logic [2:0] {
        StDest,
        StSrc,
        StHdr,
        StPayload,
        StDrop
    } dec_state_e;

endpackage

// File: rtl/osd_ctm_trace_decoder_if.sv
// Flit input and trace-record output bundle of the CTM trace decoder.
interface osd_ctm_trace_decoder_if;
    import ctm_dec_package::*;

    dii_flit        debug_in;
    logic           debug_in_ready;
    logic           rec_valid;
    logic           rec_ready;
    ctm_trace_rec_t rec;

    modport master (
        output debug_in,
        input  debug_in_ready,
        input  rec_valid,
        output rec_ready,
        input  rec
    );

    modport slave (
        input  debug_in,
        output debug_in_ready,
        output rec_valid,
        input  rec_ready,
        output rec
    );
endinterface

// File: rtl/osd_ctm_rec_fifo.sv
// Synchronous FIFO of trace records; output is read from registered storage so a
// written record becomes visible the cycle after the push.
module osd_ctm_rec_fifo
    import ctm_dec_package::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  ctm_trace_rec_t wdata_i,
    input  logic           pop_i,
    output ctm_trace_rec_t rdata_o,
    output logic           full_o,
    output logic           empty_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    ctm_trace_rec_t mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [AW:0]    cnt_q;
    logic           do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

// File: rtl/osd_ctm_trace_decoder.sv
// Reassembles CTM trace-event DII packets addressed to id_i into trace records.
// Define OSD_CTM_DEC_OVERFLOW_EN to decode overflow packets into lost_events_o.
module osd_ctm_trace_decoder
    import ctm_dec_package::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             id_i,
    osd_ctm_trace_decoder_if.slave  bus,
    output logic [ERR_W-1:0]        err_cnt_o,
    output logic [15:0]             lost_events_o
);
    localparam logic [2:0] LAST_IDX = 3'(TRACE_PAYLOAD_FLITS - 1);

    dec_state_e     state_q;
    logic [2:0]     idx_q;
    logic           ovf_q;
    logic [15:0]    shadow_q [TRACE_PAYLOAD_FLITS-1];
    logic [ERR_W-1:0] err_q;
    logic [15:0]    lost_q;

    logic           fifo_full, fifo_empty, pop, acc, push;
    logic [15:0]    din;
    ctm_trace_rec_t push_rec;

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign din  = bus.debug_in.data;
    assign pop  = bus.rec_ready && !fifo_empty;
    assign bus.debug_in_ready = !(state_q == StPayload && idx_q == LAST_IDX && fifo_full && !pop);
    assign acc  = bus.debug_in.valid && bus.debug_in_ready;
    assign push = acc && state_q == StPayload && !ovf_q && idx_q == LAST_IDX
                  && bus.debug_in.last;
    assign push_rec = '{time_stamp: {shadow_q[1], shadow_q[0]},
                        npc:        {shadow_q[3], shadow_q[2]},
                        pc:         {shadow_q[5], shadow_q[4]},
                        flags:      din[7:0]};

`ifdef OSD_CTM_DEC_OVERFLOW_EN
    logic [16:0] lost_sum;
    assign lost_sum = {1'b0, lost_q} + {1'b0, din};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StDest;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= '0;
            lost_q  <= '0;
            for (int i = 0; i < TRACE_PAYLOAD_FLITS - 1; i++) shadow_q[i] <= '0;
        end else if (acc) begin
            unique case (state_q)
                StDest: begin
                    if (bus.debug_in.last) begin
                        err_q <= err_sat_inc(err_q);
                    end else if (din != id_i) begin
                        state_q <= StDrop;
                    end else begin
                        state_q <= StSrc;
                    end
                end
                StSrc: begin
                    if (bus.debug_in.last) begin
                        err_q   <= err_sat_inc(err_q);
                        state_q <= StDest;
                    end else begin
                        state_q <= StHdr;
                    end
                end
                StHdr: begin
                    idx_q <= '0;
                    if (bus.debug_in.last) begin
                        err_q   <= err_sat_inc(err_q);
                        state_q <= StDest;
                    end else if (din[15:14] == TYPE_EVENT && din[13:10] == SUB_TRACE) begin
                        ovf_q   <= 1'b0;
                        state_q <= StPayload;
`ifdef OSD_CTM_DEC_OVERFLOW_EN
                    end else if (din[15:14] == TYPE_EVENT && din[13:10] == SUB_OVF) begin
                        ovf_q   <= 1'b1;
                        state_q <= StPayload;
`endif
                    end else begin
                        err_q   <= err_sat_inc(err_q);
                        state_q <= StDrop;
                    end
                end
                StPayload: begin
                    if (ovf_q) begin
                        if (bus.debug_in.last) begin
`ifdef OSD_CTM_DEC_OVERFLOW_EN
                            lost_q <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
`endif
                            state_q <= StDest;
                        end else begin
                            err_q   <= err_sat_inc(err_q);
                            state_q <= StDrop;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        // Record push itself happens combinationally via 'push'.
                        if (!bus.debug_in.last) err_q <= err_sat_inc(err_q);
                        state_q <= bus.debug_in.last ? StDest : StDrop;
                    end else begin
                        shadow_q[idx_q] <= din;
                        if (bus.debug_in.last) begin
                            err_q   <= err_sat_inc(err_q);
                            state_q <= StDest;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                StDrop: begin
                    if (bus.debug_in.last) state_q <= StDest;
                end
                default: state_q <= StDest;
            endcase
        end
    end

    osd_ctm_rec_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_rec),
        .pop_i   (bus.rec_ready),
        .rdata_o (bus.rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.rec_valid = !fifo_empty;
    assign err_cnt_o     = err_q;
`ifdef OSD_CTM_DEC_OVERFLOW_EN
    assign lost_events_o = lost_q;
`else
    assign lost_events_o = 16'h0;
`endif
endmodule

// File: tb/tb_osd_ctm_trace_decoder.sv
// Self-checking bench for osd_ctm_trace_decoder: vector table, directed corner sequences
// and randomized packets scored against a packet-level reference model.
module tb_osd_ctm_trace_decoder;
    import ctm_dec_package::*;

    localparam logic [15:0] ID      = 16'h0005;
    localparam logic [15:0] HDR_TRC = 16'h8000;
    localparam logic [15:0] HDR_OVF = 16'h9400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] id;
    logic [7:0]  err_cnt;
    logic [15:0] lost_events;

    osd_ctm_trace_decoder_if bus();

    osd_ctm_trace_decoder #(
        .FIFO_DEPTH (4),
        .ERR_W      (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_i          (id),
        .bus           (bus),
        .err_cnt_o     (err_cnt),
        .lost_events_o (lost_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned len;
        logic [15:0] dest;
        logic [15:0] hdr;
        int unsigned exp_rec;
        int unsigned exp_err;
    } vec_t;

    int             n_chk = 0;
    int             n_pass = 0;
    logic [15:0]    pkt_q[$];
    ctm_trace_rec_t got_q[$];
    ctm_trace_rec_t exp_q[$];
    int             exp_err = 0;
    int             exp_lost = 0;
    bit             rand_rdy = 1'b0;

    // Records leave on the posedge after a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (rst_n && bus.rec_valid && bus.rec_ready) got_q.push_back(bus.rec);
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #2;
            bus.rec_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_flit(input logic [15:0] d, input logic l);
        int budget;
        budget = 300;
        bus.debug_in.data  = d;
        bus.debug_in.valid = 1'b1;
        bus.debug_in.last  = l;
        while (!bus.debug_in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("ready_timeout", 128'(bus.debug_in_ready), 128'(1));
        tick();
        bus.debug_in.valid = 1'b0;
        bus.debug_in.last  = 1'b0;
    endtask

    task automatic send_range(input int first, input int last_excl);
        for (int i = first; i < last_excl; i++) send_flit(pkt_q[i], 1'(i == pkt_q.size() - 1));
    endtask

    task automatic send_pkt();
        send_range(0, pkt_q.size());
    endtask

    function automatic void build(input logic [15:0] dest, input logic [15:0] hdr,
                                  input ctm_trace_rec_t r, input int unsigned len);
        logic [15:0] pl [7];
        pl = '{r.time_stamp[15:0], r.time_stamp[31:16], r.npc[15:0], r.npc[31:16],
               r.pc[15:0], r.pc[31:16], {8'h00, r.flags}};
        pkt_q.delete();
        pkt_q.push_back(dest);
        pkt_q.push_back(16'h0001);
        pkt_q.push_back(hdr);
        for (int i = 0; i < 7; i++) pkt_q.push_back(pl[i]);
        while (pkt_q.size() > len) void'(pkt_q.pop_back());
        while (pkt_q.size() < len) pkt_q.push_back(16'hDEAD);
    endfunction

    function automatic ctm_trace_rec_t rand_rec();
        ctm_trace_rec_t r;
        r.time_stamp = $urandom;
        r.npc        = $urandom;
        r.pc         = $urandom;
        r.flags      = 8'($urandom);
        return r;
    endfunction

    // Packet-level reference: classifies a whole packet from its flit list.
    function automatic void model();
        int n;
        logic [15:0] h;
        n = pkt_q.size();
        h = (n > 2) ? pkt_q[2] : 16'h0;
        if (n == 1) begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end else if (pkt_q[0] != ID) begin
            // not for us
        end else if (n <= 3) begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end else if (h[15:14] == 2'b10 && h[13:10] == 4'h0) begin
            if (n == 10) exp_q.push_back('{time_stamp: {pkt_q[4], pkt_q[3]},
                                           npc: {pkt_q[6], pkt_q[5]},
                                           pc: {pkt_q[8], pkt_q[7]},
                                           flags: pkt_q[9][7:0]});
            else exp_err = (exp_err < 255) ? exp_err + 1 : 255;
`ifdef OSD_CTM_DEC_OVERFLOW_EN
        end else if (h[15:14] == 2'b10 && h[13:10] == 4'h5) begin
            if (n == 4) exp_lost = (exp_lost + int'(pkt_q[3]) > 65535) ? 65535
                                                                        : exp_lost + int'(pkt_q[3]);
            else exp_err = (exp_err < 255) ? exp_err + 1 : 255;
`endif
        end else begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           tbl [10];
        ctm_trace_rec_t t1, r;
        ctm_trace_rec_t t3 [5];
        int             kind, len;
        logic [15:0]    hdr;

        t1 = '{time_stamp: 32'h0000_1234, npc: 32'h8000_0010, pc: 32'h8000_000C, flags: 8'h41};
        tbl[0] = '{"good",        10, ID,       HDR_TRC, 1, 0};
        tbl[1] = '{"wrong_dest",  10, 16'h0006, HDR_TRC, 0, 0};
        tbl[2] = '{"last_idx3",    7, ID,       HDR_TRC, 0, 1};
        tbl[3] = '{"len11",       11, ID,       HDR_TRC, 0, 1};
        tbl[4] = '{"good2",       10, ID,       HDR_TRC, 1, 0};
        tbl[5] = '{"last_src",     2, ID,       HDR_TRC, 0, 1};
        tbl[6] = '{"last_hdr",     3, ID,       HDR_TRC, 0, 1};
        tbl[7] = '{"bad_type",    10, ID,       16'h4000, 0, 1};
        tbl[8] = '{"bad_sub",     10, ID,       16'h8400, 0, 1};
        tbl[9] = '{"last_idx5",    9, ID,       HDR_TRC, 0, 1};

        id = ID;
        bus.debug_in  = '0;
        bus.rec_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 128'(bus.debug_in_ready), 128'(1));
        chk("rst_valid", 128'(bus.rec_valid), 128'(0));
        chk("rst_rec", 128'(bus.rec), 128'(0));
        chk("rst_err", 128'(err_cnt), 128'(0));
        chk("rst_lost", 128'(lost_events), 128'(0));

        // Single packet, record visible one cycle after its last flit.
        build(ID, HDR_TRC, t1, 10);
        send_range(0, 9);
        chk("t1_pre_valid", 128'(bus.rec_valid), 128'(0));
        send_range(9, 10);
        chk("t1_valid", 128'(bus.rec_valid), 128'(1));
        chk("t1_rec", 128'(bus.rec), 128'(t1));
        bus.rec_ready = 1'b1;
        repeat (2) tick();
        chk("t1_nrec", 128'(got_q.size()), 128'(1));
        if (got_q.size() > 0) chk("t1_got", 128'(got_q.pop_front()), 128'(t1));

        foreach (tbl[i]) begin
            r = t1;
            r.time_stamp = r.time_stamp + 32'(i);
            build(tbl[i].dest, tbl[i].hdr, r, tbl[i].len);
            send_pkt();
            repeat (3) tick();
            chk({tbl[i].name, "_nrec"}, 128'(got_q.size()), 128'(tbl[i].exp_rec));
            if (got_q.size() > 0) chk({tbl[i].name, "_rec"}, 128'(got_q.pop_front()), 128'(r));
            got_q.delete();
            exp_err += tbl[i].exp_err;
            chk({tbl[i].name, "_err"}, 128'(err_cnt), 128'(exp_err));
        end

        // Back-pressure: FIFO of 4 fills, 5th packet's last flit stalls until a pop.
        bus.rec_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) t3[i] = rand_rec();
        for (int i = 0; i < 4; i++) begin
            build(ID, HDR_TRC, t3[i], 10);
            send_pkt();
        end
        build(ID, HDR_TRC, t3[4], 10);
        send_range(0, 9);
        bus.debug_in.data  = pkt_q[9];
        bus.debug_in.valid = 1'b1;
        bus.debug_in.last  = 1'b1;
        chk("t3_ready_full", 128'(bus.debug_in_ready), 128'(0));
        tick();
        chk("t3_ready_hold", 128'(bus.debug_in_ready), 128'(0));
        chk("t3_valid_hold", 128'(bus.rec_valid), 128'(1));
        bus.rec_ready = 1'b1;
        #1;
        chk("t3_ready_on_pop", 128'(bus.debug_in_ready), 128'(1));
        tick();
        bus.debug_in.valid = 1'b0;
        bus.debug_in.last  = 1'b0;
        repeat (10) tick();
        chk("t3_nrec", 128'(got_q.size()), 128'(5));
        for (int i = 0; i < 5; i++) begin
            if (got_q.size() > 0) chk($sformatf("t3_rec%0d", i), 128'(got_q.pop_front()),
                                      128'(t3[i]));
        end
        got_q.delete();
        chk("t3_err", 128'(err_cnt), 128'(exp_err));

        // Overflow packets: saturating lost_events when enabled, errors otherwise.
        build(ID, HDR_OVF, '{time_stamp: 32'h0000_FFF0, npc: 0, pc: 0, flags: 0}, 4);
        send_pkt();
        build(ID, HDR_OVF, '{time_stamp: 32'h0000_0020, npc: 0, pc: 0, flags: 0}, 4);
        send_pkt();
        tick();
`ifdef OSD_CTM_DEC_OVERFLOW_EN
        chk("ovf_lost", 128'(lost_events), 128'(16'hFFFF));
        chk("ovf_err", 128'(err_cnt), 128'(exp_err));
        exp_lost = 65535;
`else
        chk("ovf_lost", 128'(lost_events), 128'(16'h0));
        exp_err += 2;
        chk("ovf_err", 128'(err_cnt), 128'(exp_err));
`endif
        build(ID, HDR_OVF, '{time_stamp: 32'h0000_0001, npc: 0, pc: 0, flags: 0}, 5);
        send_pkt();
        tick();
        exp_err++;
        chk("ovf_len_err", 128'(err_cnt), 128'(exp_err));
        chk("ovf_len_lost", 128'(lost_events), 128'(exp_lost));

        // Asynchronous reset mid-payload with a record still buffered.
        bus.rec_ready = 1'b0;
        build(ID, HDR_TRC, t1, 10);
        send_pkt();
        build(ID, HDR_TRC, t3[0], 10);
        send_range(0, 7);
        bus.debug_in.data  = pkt_q[7];
        bus.debug_in.valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(bus.rec_valid), 128'(0));
        chk("rst_mid_rec", 128'(bus.rec), 128'(0));
        chk("rst_mid_err", 128'(err_cnt), 128'(0));
        chk("rst_mid_lost", 128'(lost_events), 128'(0));
        bus.debug_in.valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_ready", 128'(bus.debug_in_ready), 128'(1));
        exp_err  = 0;
        exp_lost = 0;
        got_q.delete();
        bus.rec_ready = 1'b1;
        build(ID, HDR_TRC, t3[1], 10);
        send_pkt();
        repeat (3) tick();
        chk("rst_post_nrec", 128'(got_q.size()), 128'(1));
        if (got_q.size() > 0) chk("rst_post_rec", 128'(got_q.pop_front()), 128'(t3[1]));
        got_q.delete();

        // Randomized packets against the reference model, with random consumer stalls.
        exp_q.delete();
        rand_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: build(ID, HDR_TRC, rand_rec(), 10);
                2: build(ID ^ 16'h0100, HDR_TRC, rand_rec(), $urandom_range(1, 12));
                3: begin
                    len = $urandom_range(1, 12);
                    if (len == 10) len = 9;
                    build(ID, HDR_TRC, rand_rec(), len);
                end
                4: begin
                    hdr = 16'($urandom);
                    if (hdr[15:14] == 2'b10 && (hdr[13:10] == 4'h0 || hdr[13:10] == 4'h5))
                        hdr[15:14] = 2'b01;
                    build(ID, hdr, rand_rec(), $urandom_range(1, 12));
                end
                default: build(ID, HDR_OVF | 16'($urandom_range(0, 1023)), rand_rec(),
                               $urandom_range(3, 5));
            endcase
            model();
            send_pkt();
        end
        rand_rdy = 1'b0;
        tick();
        bus.rec_ready = 1'b1;
        repeat (20) tick();
        chk("rand_nrec", 128'(got_q.size()), 128'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk("rand_rec", 128'(got_q.pop_front()), 128'(exp_q.pop_front()));
        chk("rand_err", 128'(err_cnt), 128'(exp_err));
        chk("rand_lost", 128'(lost_events), 128'(exp_lost));

        // Error counter saturates rather than wrapping.
        for (int i = 0; i < 260; i++) begin
            pkt_q.delete();
            pkt_q.push_back(ID);
            model();
            send_pkt();
        end
        tick();
        chk("err_sat_model", 128'(err_cnt), 128'(exp_err));
        chk("err_sat_ones", 128'(err_cnt), 128'(8'hFF));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
